// File: rtl/rv64i_control_unit.sv
// Multicycle control FSM for the RV64I core: fetch, decode, execute, mem.
// Ports: clock/reset, imem and dmem handshakes, opcode/funct fields, ALU flags, datapath selects.
module rv64i_control_unit (
  input  logic       clock,
  input  logic       reset,
  output logic       instruction_mem_enable,
  input  logic       instruction_mem_busy,
  output logic       data_mem_enable,
  output logic [7:0] data_mem_byte_write_enable,
  input  logic       data_mem_busy,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       negative,
  input  logic       carry_out,
  input  logic       overflow,
  output logic       alua_src,
  output logic       alub_src,
  output logic       aluy_src,
  output logic [2:0] alu_src,
  output logic       sub,
  output logic       arithmetic,
  output logic       alupc_src,
  output logic       pc_src,
  output logic       pc_enable,
  output logic [2:0] read_data_src,
  output logic [1:0] write_register_src,
  output logic       write_register_enable
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM_DONE
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_R32  = 7'b0111011;
  localparam logic [6:0] OP_I32  = 7'b0011011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;

  state_t state;
  state_t state_n;
  logic   seen;
  logic   seen_n;

  logic is_r, is_i, is_r32, is_i32;
  logic is_alu, is_load, is_store, is_mem;
  logic take;
  logic [7:0] lanes;
  logic unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign is_r     = opcode == OP_R;
  assign is_i     = opcode == OP_I;
  assign is_r32   = opcode == OP_R32;
  assign is_i32   = opcode == OP_I32;
  assign is_alu   = is_r | is_i | is_r32 | is_i32;
  assign is_load  = opcode == OP_LD;
  assign is_store = opcode == OP_ST;
  assign is_mem   = is_load | is_store;

  // Branch condition from the flags of rs1 - rs2; funct3[0] inverts.
  always_comb begin
    take = 1'b0;
    case (funct3[2:1])
      2'b00:   take = zero ^ funct3[0];
      2'b10:   take = negative ^ overflow ^ funct3[0];
      2'b11:   take = carry_out == funct3[0];
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    lanes = 8'h00;
    case (funct3[1:0])
      2'b00:   lanes = 8'h01;
      2'b01:   lanes = 8'h03;
      2'b10:   lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      seen  <= seen_n;
    end
  end

  always_comb begin
    state_n                    = state;
    seen_n                     = seen;
    instruction_mem_enable     = 1'b0;
    data_mem_enable            = 1'b0;
    data_mem_byte_write_enable = 8'h00;
    alua_src                   = 1'b0;
    alub_src                   = 1'b0;
    aluy_src                   = 1'b0;
    alu_src                    = 3'b000;
    sub                        = 1'b0;
    arithmetic                 = 1'b0;
    alupc_src                  = 1'b0;
    pc_src                     = 1'b0;
    pc_enable                  = 1'b0;
    read_data_src              = 3'b000;
    write_register_src         = 2'b00;
    write_register_enable      = 1'b0;

    // Selects stay valid through MEM_DONE so the load result path holds.
    if (state == EXECUTE || state == MEM_DONE) begin
      unique case (1'b1)
        is_alu: begin
          alu_src    = funct3;
          alub_src   = is_i | is_i32;
          aluy_src   = is_r32 | is_i32;
          sub        = (funct3[2:1] == 2'b01) |
                       ((funct3 == 3'b000) & funct7[5] & (is_r | is_r32));
          arithmetic = (funct3 == 3'b101) & funct7[5];
          write_register_enable = 1'b1;
        end
        opcode == OP_LUI: begin
          write_register_src    = 2'b11;
          write_register_enable = 1'b1;
        end
        opcode == OP_AUI: begin
          alua_src              = 1'b1;
          alub_src              = 1'b1;
          write_register_enable = 1'b1;
        end
        opcode == OP_JAL: begin
          pc_src                = 1'b1;
          write_register_src    = 2'b10;
          write_register_enable = 1'b1;
        end
        opcode == OP_JALR: begin
          alub_src              = 1'b1;
          pc_src                = 1'b1;
          alupc_src             = 1'b1;
          write_register_src    = 2'b10;
          write_register_enable = 1'b1;
        end
        opcode == OP_BR: begin
          sub    = 1'b1;
          pc_src = take;
        end
        is_load: begin
          alub_src           = 1'b1;
          read_data_src      = funct3;
          write_register_src = 2'b01;
        end
        is_store: begin
          alub_src = 1'b1;
        end
        default: begin
        end
      endcase
    end

    unique case (state)
      IDLE: begin
        state_n = FETCH;
        seen_n  = 1'b0;
      end
      FETCH: begin
        instruction_mem_enable = 1'b1;
        if (instruction_mem_busy) begin
          seen_n = 1'b1;
        end else if (seen) begin
          seen_n  = 1'b0;
          state_n = DECODE;
        end
      end
      DECODE: begin
        state_n = EXECUTE;
      end
      EXECUTE: begin
        if (is_mem) begin
          data_mem_enable       = 1'b1;
          write_register_enable = 1'b0;
          if (is_store) begin
            data_mem_byte_write_enable = lanes;
          end
          if (data_mem_busy) begin
            seen_n = 1'b1;
          end else if (seen) begin
            seen_n  = 1'b0;
            state_n = MEM_DONE;
          end
        end else begin
          pc_enable = 1'b1;
          state_n   = FETCH;
        end
      end
      MEM_DONE: begin
        pc_enable             = 1'b1;
        write_register_enable = is_load;
        state_n               = FETCH;
      end
      default: begin
        state_n = IDLE;
        seen_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv64i_control_unit.sv
// Self-checking bench for rv64i_control_unit: directed plus random instructions
// against an instruction-level reference model of the control outputs.
module tb_rv64i_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       instruction_mem_enable;
  logic       instruction_mem_busy;
  logic       data_mem_enable;
  logic [7:0] data_mem_byte_write_enable;
  logic       data_mem_busy;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, negative, carry_out, overflow;
  logic       alua_src, alub_src, aluy_src;
  logic [2:0] alu_src;
  logic       sub, arithmetic, alupc_src, pc_src, pc_enable;
  logic [2:0] read_data_src;
  logic [1:0] write_register_src;
  logic       write_register_enable;

  int checks = 0;
  int failures = 0;

  localparam int PH_IDLE = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_DEC = 2;
  localparam int PH_EXEC = 3;
  localparam int PH_DONE = 4;

  rv64i_control_unit dut (
    .clock                      (clock),
    .reset                      (reset),
    .instruction_mem_enable     (instruction_mem_enable),
    .instruction_mem_busy       (instruction_mem_busy),
    .data_mem_enable            (data_mem_enable),
    .data_mem_byte_write_enable (data_mem_byte_write_enable),
    .data_mem_busy              (data_mem_busy),
    .opcode                     (opcode),
    .funct3                     (funct3),
    .funct7                     (funct7),
    .zero                       (zero),
    .negative                   (negative),
    .carry_out                  (carry_out),
    .overflow                   (overflow),
    .alua_src                   (alua_src),
    .alub_src                   (alub_src),
    .aluy_src                   (aluy_src),
    .alu_src                    (alu_src),
    .sub                        (sub),
    .arithmetic                 (arithmetic),
    .alupc_src                  (alupc_src),
    .pc_src                     (pc_src),
    .pc_enable                  (pc_enable),
    .read_data_src              (read_data_src),
    .write_register_src         (write_register_src),
    .write_register_enable      (write_register_enable)
  );

  always #5 clock = ~clock;

  function automatic logic [26:0] observed();
    return {instruction_mem_enable, data_mem_enable,
            data_mem_byte_write_enable, alua_src, alub_src,
            aluy_src, alu_src, sub, arithmetic, alupc_src,
            pc_src, pc_enable, read_data_src,
            write_register_src, write_register_enable};
  endfunction

  // Expected outputs for an instruction in a given phase.
  function automatic logic [26:0] model(int ph, logic [6:0] op,
                                        logic [2:0] f3, logic [6:0] f7,
                                        logic z, logic n, logic c,
                                        logic v);
    logic ime, dme, a, b, y, s, ar, jp, ps, pe, we;
    logic [7:0] be;
    logic [2:0] al, rd;
    logic [1:0] ws;
    logic mem, run;
    {ime, dme, a, b, y, s, ar, jp, ps, pe, we} = '0;
    be = 8'h00; al = 3'b000; rd = 3'b000; ws = 2'b00;
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    run = (ph == PH_EXEC) || (ph == PH_DONE);
    if (ph == PH_FETCH) ime = 1'b1;
    if (run) begin
      case (op)
        7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011: begin
          al = f3;
          b  = (op == 7'b0010011) || (op == 7'b0011011);
          y  = (op == 7'b0111011) || (op == 7'b0011011);
          s  = (f3 == 3'd2) || (f3 == 3'd3) ||
               (f3 == 3'd0 && f7[5] && !b);
          ar = (f3 == 3'd5) && f7[5];
          we = 1'b1;
        end
        7'b0110111: begin ws = 2'd3; we = 1'b1; end
        7'b0010111: begin a = 1'b1; b = 1'b1; we = 1'b1; end
        7'b1101111: begin ps = 1'b1; ws = 2'd2; we = 1'b1; end
        7'b1100111: begin
          b = 1'b1; ps = 1'b1; jp = 1'b1; ws = 2'd2; we = 1'b1;
        end
        7'b1100011: begin
          s = 1'b1;
          case (f3)
            3'd0: ps = z;
            3'd1: ps = !z;
            3'd4: ps = (n != v);
            3'd5: ps = (n == v);
            3'd6: ps = !c;
            3'd7: ps = c;
            default: ps = 1'b0;
          endcase
        end
        7'b0000011: begin
          b = 1'b1; rd = f3; ws = 2'd1;
          dme = (ph == PH_EXEC);
          we  = (ph == PH_DONE);
        end
        7'b0100011: begin
          b = 1'b1;
          dme = (ph == PH_EXEC);
          if (ph == PH_EXEC) begin
            case (f3[1:0])
              2'd0: be = 8'h01;
              2'd1: be = 8'h03;
              2'd2: be = 8'h0F;
              default: be = 8'hFF;
            endcase
          end
        end
        default: ;
      endcase
      pe = (ph == PH_DONE) || !mem;
    end
    return {ime, dme, be, a, b, y, al, s, ar, jp, ps, pe, rd, ws, we};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(string tag, logic [26:0] exp);
    logic [26:0] got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with the FSM in FETCH; leaves it in FETCH.
  task automatic run_instr(string tag, logic [6:0] op, logic [2:0] f3,
                           logic [6:0] f7, logic [3:0] fl,
                           int fb, int mb);
    logic mem;
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    check({tag, ":fetch"}, model(PH_FETCH, op, f3, f7, 0, 0, 0, 0));
    opcode = op; funct3 = f3; funct7 = f7;
    {zero, negative, carry_out, overflow} = fl;
    instruction_mem_busy = 1'b1;
    for (int i = 0; i < fb; i++) begin
      step();
      check({tag, ":fwait"}, model(PH_FETCH, op, f3, f7, 0, 0, 0, 0));
    end
    instruction_mem_busy = 1'b0;
    step();
    check({tag, ":decode"}, model(PH_DEC, op, f3, f7, 0, 0, 0, 0));
    step();
    check({tag, ":exec"},
          model(PH_EXEC, op, f3, f7, fl[3], fl[2], fl[1], fl[0]));
    if (mem) begin
      data_mem_busy = 1'b1;
      for (int i = 0; i < mb; i++) begin
        step();
        check({tag, ":mwait"},
              model(PH_EXEC, op, f3, f7, fl[3], fl[2], fl[1], fl[0]));
      end
      data_mem_busy = 1'b0;
      step();
      check({tag, ":done"},
            model(PH_DONE, op, f3, f7, fl[3], fl[2], fl[1], fl[0]));
    end
    step();
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] fl;
    int k;
    reset = 1'b0;
    instruction_mem_busy = 1'b0;
    data_mem_busy = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    {zero, negative, carry_out, overflow} = 4'b0;

    step();
    check("reset", 27'd0);
    reset = 1'b1;
    step();
    check("fetch_after_reset", model(PH_FETCH, 0, 0, 0, 0, 0, 0, 0));
    // No busy pulse yet: FETCH must hold.
    repeat (3) begin
      step();
      check("fetch_hold", model(PH_FETCH, 0, 0, 0, 0, 0, 0, 0));
    end

    run_instr("addi", 7'b0010011, 3'b000, 7'b0000000, 4'b0, 1, 0);
    run_instr("sraiw", 7'b0011011, 3'b101, 7'b0100000, 4'b0, 2, 0);
    run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 4'b0, 1, 0);
    run_instr("bltu_c0", 7'b1100011, 3'b110, 7'd0, 4'b0000, 1, 0);
    run_instr("bltu_c1", 7'b1100011, 3'b110, 7'd0, 4'b0010, 1, 0);
    run_instr("bne_z0", 7'b1100011, 3'b001, 7'd0, 4'b0000, 1, 0);
    run_instr("bge_n1", 7'b1100011, 3'b101, 7'd0, 4'b0100, 1, 0);
    run_instr("sd", 7'b0100011, 3'b011, 7'd0, 4'b0, 1, 1);
    run_instr("lw", 7'b0000011, 3'b010, 7'd0, 4'b0, 1, 3);
    run_instr("jalr", 7'b1100111, 3'b000, 7'd0, 4'b0, 1, 0);
    run_instr("lui", 7'b0110111, 3'b000, 7'd0, 4'b0, 1, 0);
    run_instr("bad_op", 7'b1111111, 3'b111, 7'h7F, 4'b1111, 1, 0);

    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 11);
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      fl = 4'($urandom);
      case (k)
        0: begin
          op = 7'b0110011;
          f7 = ((f3 == 0 || f3 == 5) && f7[0]) ? 7'h20 : 7'h00;
        end
        1: begin
          op = 7'b0010011;
          if (f3 == 1) f7 = 7'h00;
          if (f3 == 5) f7 = f7[0] ? 7'h20 : 7'h00;
        end
        2, 3: begin
          op = (k == 2) ? 7'b0111011 : 7'b0011011;
          case (f3[1:0])
            2'd0: f3 = 3'd0;
            2'd1: f3 = 3'd1;
            default: f3 = 3'd5;
          endcase
          if (k == 2 || f3 != 0) f7 = f7[0] ? 7'h20 : 7'h00;
          if (f3 == 1) f7 = 7'h00;
        end
        4: op = 7'b0110111;
        5: op = 7'b0010111;
        6: op = 7'b1101111;
        7: begin op = 7'b1100111; f3 = 3'd0; end
        8: op = 7'b1100011;
        9: begin op = 7'b0000011; if (f3 == 7) f3 = 3'd6; end
        10: begin op = 7'b0100011; f3 = {1'b0, f3[1:0]}; end
        default: op = 7'b0001111 ^ 7'($urandom_range(0, 1) << 6);
      endcase
      run_instr($sformatf("rnd%0d", t), op, f3, f7, fl,
                $urandom_range(1, 3), $urandom_range(1, 3));
    end

    // Reset while a load is pending on data memory.
    opcode = 7'b0000011; funct3 = 3'b011;
    instruction_mem_busy = 1'b1;
    step();
    instruction_mem_busy = 1'b0;
    step();
    step();
    check("lw_exec_pre_reset", model(PH_EXEC, 7'b0000011, 3'b011, 0,
                                     0, 0, 0, 0));
    data_mem_busy = 1'b1;
    reset = 1'b0;
    step();
    check("mid_reset_idle", 27'd0);
    reset = 1'b1;
    data_mem_busy = 1'b0;
    step();
    check("mid_reset_fetch", model(PH_FETCH, 0, 0, 0, 0, 0, 0, 0));
    step();
    check("mid_reset_hold", model(PH_FETCH, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv64i_control_unit.md
Name: rv64i_control_unit

Overview:
- Multicycle control unit for the RV64I core.
- Sequences instruction fetch from the busy-handshaked instruction ROM, decodes opcode/funct3/funct7 from the dataflow, drives all datapath selects, and handshakes with data memory for loads/stores.
- PC register, immediate extender and memories are external.

Parameters:
- none

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low reset
- instruction_mem_enable  out  1  request instruction read
- instruction_mem_busy  in  1  instruction memory busy
- data_mem_enable  out  1  data memory access request
- data_mem_byte_write_enable  out  8  store byte lanes
- data_mem_busy  in  1  data memory busy
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- zero, negative, carry_out, overflow  in  1 each  ALU flags of the current operation
- alua_src  out  1  ALU A: 0 rs1, 1 PC
- alub_src  out  1  ALU B: 0 rs2, 1 immediate
- aluy_src  out  1  0 full 64-bit result, 1 low 32 bits sign-extended (W ops)
- alu_src  out  3  ALU op = funct3 encoding (000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 shift right, 110 or, 111 and)
- sub  out  1  subtract / compare
- arithmetic  out  1  arithmetic right shift
- alupc_src  out  1  jump target: 0 PC+imm, 1 ALU result (rs1+imm, JALR)
- pc_src  out  1  next PC: 0 PC+4, 1 target
- pc_enable  out  1  PC register load
- read_data_src  out  3  load size/sign = load funct3
- write_register_src  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate
- write_register_enable  out  1  register file write

Behaviour:
- Reset (reset=0 at rising edge):
  - enter IDLE; all outputs 0.
  - IDLE -> FETCH on the first edge with reset=1.
- FETCH:
  - instruction_mem_enable=1; all other outputs 0.
  - Wait until instruction_mem_busy is sampled 1, then go to DECODE on the first edge sampling it 0.
- DECODE: one cycle, all outputs 0 (including instruction_mem_enable, pc_enable, write_register_enable).
- EXECUTE: datapath selects per instruction class:
  - OP / OP-IMM / OP-32 / OP-IMM-32:
    - alu_src=funct3.
    - alub_src=1 for I-forms.
    - aluy_src=1 for the -32 forms.
    - sub=1 for SUB/SUBW/SLT(I)/SLTU(I).
    - arithmetic=1 when funct7[5]=1 on funct3=101.
    - write_register_src=00, write_register_enable=1.
  - LUI: write_register_src=11, write_register_enable=1.
  - AUIPC: alua_src=1, alub_src=1, write_register_src=00, write_register_enable=1.
  - JAL: pc_src=1, alupc_src=0, write_register_src=10, write_register_enable=1.
  - JALR: alub_src=1, pc_src=1, alupc_src=1, write_register_src=10, write_register_enable=1.
  - Branch: sub=1, alu_src=000, write_register_enable=0. pc_src combinational from the flags:
    - funct3[2:1]=00: pc_src = zero XOR funct3[0].
    - funct3[2:1]=10: pc_src = negative XOR overflow XOR funct3[0].
    - funct3[2:1]=11: pc_src = (carry_out == funct3[0]).
    - funct3[2:1]=01 (invalid): pc_src=0.
  - Load: alub_src=1, data_mem_enable=1, read_data_src=funct3, write_register_src=01, write_register_enable=0 during the access.
  - Store: alub_src=1, data_mem_enable=1, write_register_enable=0. data_mem_byte_write_enable is 0x01 (SB), 0x03 (SH), 0x0F (SW) or 0xFF (SD).
  - Every other output is 0.
- Non-memory instructions:
  - EXECUTE lasts one cycle with pc_enable=1, then FETCH.
- Load/store:
  - Stay in EXECUTE until data_mem_busy is sampled 1, then go to MEM_DONE on the first edge sampling it 0.
  - MEM_DONE: one cycle with pc_enable=1, data_mem_enable=0, byte enables 0, selects held, and write_register_enable=1 only for loads. Then FETCH.
- Unrecognized opcode: EXECUTE with all selects 0, pc_enable=1 (PC+4), no register or memory write.
- reset=0 in any state: return to IDLE at that edge; all outputs 0 and any pending memory request dropped.
- pc_enable and write_register_enable are never 1 in IDLE, FETCH or DECODE.

Test Plan:
- Reset: reset=0 for one edge -> all 25 control bits, pc_enable and instruction_mem_enable are 0. After release: FETCH with instruction_mem_enable=1, pc_enable=0.
- ADDI x1,x0,5 (0x00500093): after the busy pulse, DECODE has all outputs 0. EXECUTE has alub_src=1, alu_src=000, write_register_src=00, write_register_enable=1, pc_enable=1.
- SRAIW (opcode 0011011, funct3 101, funct7 0100000): arithmetic=1, aluy_src=1, alub_src=1, alu_src=101. SUB (0110011/000/0100000): sub=1, alub_src=0.
- BLTU with carry_out=0: pc_src=1; with carry_out=1: pc_src=0. BNE with zero=0: pc_src=1. BGE with negative=1, overflow=0: pc_src=0.
- SD:
  - EXECUTE: data_mem_enable=1, byte_write_enable=0xFF.
  - After a data_mem_busy pulse: pc_enable=1, write_register_enable=0, data_mem_enable=0, byte_write_enable=0x00.
- LW:
  - EXECUTE: read_data_src=010, write_register_src=01, write_register_enable=0.
  - MEM_DONE: write_register_enable=1, pc_enable=1.
  - JALR: pc_src=1, alupc_src=1, write_register_src=10.
